// File: rtl/launchpad_key_debounce_if.sv
// Signal bundle between the launchpad key front end and its neighbours.
// master drives the raw pins, slave is the debounce block.
interface launchpad_key_debounce_if;
  logic [8:0] PAD_RAW;
  logic [3:0] LEFT_RAW;
  logic [8:0] KEY;
  logic [3:0] LEFT_KEY;
  logic [8:0] PAD_HELD;
  logic [3:0] LEFT_HELD;
  logic [3:0] LAST_PAD;

  modport master (
    output PAD_RAW, LEFT_RAW,
    input  KEY, LEFT_KEY, PAD_HELD, LEFT_HELD, LAST_PAD
  );

  modport slave (
    input  PAD_RAW, LEFT_RAW,
    output KEY, LEFT_KEY, PAD_HELD, LEFT_HELD, LAST_PAD
  );
endinterface

// File: rtl/launchpad_key_debounce.sv
// Synchronise, debounce and arbitrate 9 pad keys and 4 mode keys into one-hot press pulses.
// Optional auto-repeat of the lowest held pad key is built only when KEY_REPEAT_EN is defined.
module launchpad_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter bit RAW_ACTIVE_LOW  = 1'b1,
  parameter int REPEAT_DELAY    = 12000000,
  parameter int REPEAT_PERIOD   = 4800000
) (
  input logic CLK,
  input logic RESET,
  launchpad_key_debounce_if.slave bus
);
  localparam int NK = 13;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("REPEAT_DELAY and REPEAT_PERIOD must be positive");
  end

  function automatic logic [3:0] lowest_idx(input logic [8:0] v);
    logic [3:0] idx;
    idx = 4'hF;
    for (int i = 8; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  logic [NK-1:0] raw_n;
  logic [NK-1:0] sync1_q, sync2_q, stable_q, stable_d, held_q;
  logic [CW-1:0] cnt_q [NK];
  logic [CW-1:0] cnt_d [NK];
  logic [NK-1:0] press;
  logic [8:0]    pad_req, key_d, key_q;
  logic [3:0]    left_d, left_q, last_d, last_q;

  // Normalise so that 1 always means pressed.
  assign raw_n = RAW_ACTIVE_LOW ? ~{bus.LEFT_RAW, bus.PAD_RAW} : {bus.LEFT_RAW, bus.PAD_RAW};

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NK; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) stable_d[i] = ~stable_q[i];
        else cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // A press is a stable level that the held copy has not caught up with yet.
  assign press = stable_q & ~held_q;

`ifdef KEY_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  logic [3:0]    rep_idx_q, lo_held;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_fire;
  logic [8:0]    rep_vec;

  assign lo_held  = lowest_idx(stable_q[8:0]);
  assign rep_fire = (lo_held == rep_idx_q) && (rep_idx_q != 4'hF) && (rep_cnt_q == '0);
  assign rep_vec  = rep_fire ? (9'd1 << rep_idx_q) : 9'd0;
  assign pad_req  = press[8:0] | rep_vec;

  // Won or lost, a due repeat reloads the period.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    if (lo_held != rep_idx_q)                    rep_cnt_d = RW'(REPEAT_DELAY - 1);
    else if (rep_fire)                           rep_cnt_d = RW'(REPEAT_PERIOD - 1);
    else if (rep_idx_q != 4'hF && rep_cnt_q != '0) rep_cnt_d = rep_cnt_q - RW'(1);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rep_idx_q <= 4'hF;
      rep_cnt_q <= '0;
    end else begin
      rep_idx_q <= lo_held;
      rep_cnt_q <= rep_cnt_d;
    end
  end
`else
  assign pad_req = press[8:0];
`endif

  assign key_d  = pad_req & (~pad_req + 9'd1);
  assign left_d = press[12:9] & (~press[12:9] + 4'd1);
  assign last_d = (|key_d) ? lowest_idx(key_d) : last_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      held_q   <= '0;
      key_q    <= '0;
      left_q   <= '0;
      last_q   <= 4'hF;
      for (int i = 0; i < NK; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q  <= raw_n;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      held_q   <= stable_q;
      key_q    <= key_d;
      left_q   <= left_d;
      last_q   <= last_d;
      for (int i = 0; i < NK; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.KEY       = key_q;
  assign bus.LEFT_KEY  = left_q;
  assign bus.PAD_HELD  = held_q[8:0];
  assign bus.LEFT_HELD = held_q[12:9];
  assign bus.LAST_PAD  = last_q;
endmodule

// File: tb/tb_launchpad_key_debounce.sv
// Bench for launchpad_key_debounce: directed scenarios plus random key traffic,
// every cycle compared against a window-based behavioural model.
module tb_launchpad_key_debounce;
  localparam int DC = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  launchpad_key_debounce_if bus();

  launchpad_key_debounce #(
    .DEBOUNCE_CYCLES(DC),
    .RAW_ACTIVE_LOW (1'b0),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;
  int pulses [9];

  // model state
  logic [12:0] hist [$];
  logic [12:0] m_stable, m_held;
  logic [8:0]  m_key;
  logic [3:0]  m_left, m_last;
  int          m_rep_idx, m_rep_due, cyc;

  function automatic int lowest(input logic [12:0] v, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k <= DC; k++) hist.push_back('0);
    m_stable  = '0;
    m_held    = '0;
    m_key     = '0;
    m_left    = '0;
    m_last    = 4'hF;
    m_rep_idx = -1;
    m_rep_due = 0;
  endtask

  // A key accepts a new level once the last DC synchronised samples all disagree with it.
  task automatic model_edge(input logic [12:0] raw);
    logic [12:0] nstable, prs;
    logic [12:0] req;
    int n, w, lw;
    bit all_diff;
    n = hist.size();
    nstable = m_stable;
    for (int i = 0; i < 13; i++) begin
      all_diff = 1'b1;
      for (int k = n - 1 - DC; k <= n - 2; k++) if (hist[k][i] == m_stable[i]) all_diff = 1'b0;
      if (all_diff) nstable[i] = ~m_stable[i];
    end
    prs = m_stable & ~m_held;
    req = {4'b0, prs[8:0]};
`ifdef KEY_REPEAT_EN
    begin
      int lo;
      lo = lowest(m_stable, 0, 8);
      if (lo != m_rep_idx) begin
        m_rep_idx = lo;
        m_rep_due = cyc + RD;
      end else if (lo >= 0 && cyc == m_rep_due) begin
        req[lo] = 1'b1;
        m_rep_due = cyc + RP;
      end
    end
`endif
    w = lowest(req, 0, 8);
    m_key = (w >= 0) ? 9'(1 << w) : 9'd0;
    if (w >= 0) m_last = 4'(w);
    lw = lowest(prs, 9, 12);
    m_left = (lw >= 0) ? 4'(1 << (lw - 9)) : 4'd0;
    m_held   = m_stable;
    m_stable = nstable;
    hist.push_back(raw);
    void'(hist.pop_front());
    cyc++;
  endtask

  task automatic step();
    @(posedge CLK);
    if (RESET) model_reset();
    else model_edge({bus.LEFT_RAW, bus.PAD_RAW});
    #1;
    check("KEY",       {4'b0, bus.KEY},       {4'b0, m_key});
    check("LEFT_KEY",  {9'b0, bus.LEFT_KEY},  {9'b0, m_left});
    check("PAD_HELD",  {4'b0, bus.PAD_HELD},  {4'b0, m_held[8:0]});
    check("LEFT_HELD", {9'b0, bus.LEFT_HELD}, {9'b0, m_held[12:9]});
    check("LAST_PAD",  {9'b0, bus.LAST_PAD},  {9'b0, m_last});
    for (int i = 0; i < 9; i++) if (bus.KEY[i]) pulses[i]++;
  endtask

  task automatic run(input int n);
    for (int j = 0; j < n; j++) step();
  endtask

  task automatic drive(input logic [8:0] pad, input logic [3:0] left);
    bus.PAD_RAW  = pad;
    bus.LEFT_RAW = left;
  endtask

  task automatic clear_pulses();
    for (int i = 0; i < 9; i++) pulses[i] = 0;
  endtask

  initial begin
    logic [12:0] rnd;
    int first, cnt;
    cyc = 0;
    model_reset();
    clear_pulses();
    drive('0, '0);
    run(2);
    check("reset KEY", {4'b0, bus.KEY}, 13'h0);
    check("reset LAST_PAD", {9'b0, bus.LAST_PAD}, 13'hF);
    RESET = 1'b0;
    run(3);

    // 1: clean press
    drive(9'h008, 4'h0);
    run(7);
    check("t1 KEY", {4'b0, bus.KEY}, 13'h008);
    check("t1 HELD", {4'b0, bus.PAD_HELD}, 13'h008);
    check("t1 LAST", {9'b0, bus.LAST_PAD}, 13'h3);
    run(1);
    check("t1 KEY width", {4'b0, bus.KEY}, 13'h000);
    drive('0, '0);
    run(10);

    // 2: bounce
    clear_pulses();
    drive(9'h001, 4'h0); run(2);
    drive(9'h000, 4'h0); run(2);
    drive(9'h001, 4'h0);
    run(7);
    check("t2 KEY", {4'b0, bus.KEY}, 13'h001);
    run(10);
    check("t2 pulse count", 13'(pulses[0]), 13'd1);
    drive('0, '0);
    run(10);

    // 3: simultaneous pad presses
    clear_pulses();
    drive(9'h084, 4'h0);
    run(7);
    check("t3 KEY", {4'b0, bus.KEY}, 13'h004);
    check("t3 HELD", {4'b0, bus.PAD_HELD}, 13'h084);
    run(25);
    check("t3 no KEY7", 13'(pulses[7]), 13'd0);
    drive('0, '0);
    run(10);
    drive(9'h080, 4'h0);
    run(7);
    check("t3 KEY7 repress", {4'b0, bus.KEY}, 13'h080);
    drive('0, '0);
    run(10);

    // 4: both groups in one cycle
    drive(9'h100, 4'b0110);
    run(7);
    check("t4 LEFT_KEY", {9'b0, bus.LEFT_KEY}, 13'h2);
    check("t4 KEY", {4'b0, bus.KEY}, 13'h100);
    check("t4 LAST", {9'b0, bus.LAST_PAD}, 13'h8);
    drive('0, '0);
    run(10);
    drive('0, 4'b0001);
    run(7);
    check("t4 left only", {9'b0, bus.LEFT_KEY}, 13'h1);
    check("t4 LAST kept", {9'b0, bus.LAST_PAD}, 13'h8);
    drive('0, '0);
    run(10);

    // 5: reset in the middle of a count
    clear_pulses();
    drive(9'h020, 4'h0);
    run(4);
    RESET = 1'b1;
    run(1);
    RESET = 1'b0;
    run(6);
    check("t5 no pulse", 13'(pulses[5]), 13'd0);
    run(1);
    check("t5 KEY after reset", {4'b0, bus.KEY}, 13'h020);
    drive('0, '0);
    run(10);

    // 6: long hold
    drive(9'h010, 4'h0);
    run(7);
    check("t6 KEY", {4'b0, bus.KEY}, 13'h010);
    first = -1;
    cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (bus.KEY[4]) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
`ifdef KEY_REPEAT_EN
    check("t6 repeat count", 13'(cnt), 13'd6);
    check("t6 first repeat", 13'(first), 13'd20);
`else
    check("t6 repeat count", 13'(cnt), 13'd0);
`endif
    check("t6 LAST", {9'b0, bus.LAST_PAD}, 13'h4);
    drive('0, '0);
    run(10);

    // random traffic with occasional resets
    rnd = '0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) rnd[$urandom_range(0, 12)] ^= 1'b1;
      if ($urandom_range(0, 9) == 0) rnd[$urandom_range(0, 3)] = 1'b1;
      RESET = ($urandom_range(0, 399) == 0);
      drive(rnd[8:0], rnd[12:9]);
      step();
    end
    RESET = 1'b0;
    drive('0, '0);
    run(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
